// File: rtl/rd_resp_arbiter_pkg.sv
// Shared AXI read-response definitions: arbiter FSM states, RRESP codes, sizing helpers.
package rd_resp_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } rresp_t;

    localparam int unsigned BEAT_CNT_W = 8;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_resp_arbiter_picker.sv
// Round-robin selector: first requester strictly after last_grant, wrapping modulo N.
module rr_picker
    import rd_resp_arbiter_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = idx_width(N)
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_c,
    output logic             grant_valid_c
);

    // Walk offsets 1..N from the previous winner; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_c       = '0;
        grant_valid_c = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!grant_valid_c && req[IDX_W'(idx)]) begin
                grant_c       = IDX_W'(idx);
                grant_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_resp_arbiter.sv
// Read-response arbiter: locks one slave's R burst onto the master port, round-robin between bursts.
module rd_resp_arbiter
    import rd_resp_arbiter_pkg::*;
#(
    parameter int unsigned      NUM_SL = 2,
    parameter int unsigned      ID_W   = 8,
    parameter int unsigned      DATA_W = 32,
    parameter int unsigned      SEL_W  = 2,
    parameter logic [SEL_W-1:0] MAS_ID = SEL_W'(2'b01)
)(
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_SL-1:0]        sl_RVALID,
    input  logic [NUM_SL-1:0]        sl_RLAST,
    input  logic [NUM_SL*ID_W-1:0]   sl_RID,
    input  logic [NUM_SL*DATA_W-1:0] sl_RDATA,
    input  logic [NUM_SL*2-1:0]      sl_RRESP,
    input  logic [NUM_SL*SEL_W-1:0]  sl_mas_sel,
    output logic [NUM_SL-1:0]        sl_RREADY,
    output logic                     m_RVALID,
    output logic                     m_RLAST,
    output logic [ID_W-1:0]          m_RID,
    output logic [DATA_W-1:0]        m_RDATA,
    output logic [1:0]               m_RRESP,
    input  logic                     m_RREADY,
    output logic                     busy,
    output logic [BEAT_CNT_W-1:0]    beat_cnt
);

    localparam int unsigned IDX_W = idx_width(NUM_SL);

    arb_state_t        state;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  pick_c;
    logic              pick_valid_c;
    logic              accept_c;
    logic              out_free_c;
    logic [NUM_SL-1:0] elig_c;

    logic [ID_W-1:0]   rid_a   [NUM_SL];
    logic [DATA_W-1:0] rdata_a [NUM_SL];
    logic [1:0]        rresp_a [NUM_SL];

    // Unpack per-slave payloads and qualify each RVALID with this master's select code.
    for (genvar i = 0; i < NUM_SL; i++) begin : g_unpack
        assign rid_a[i]   = sl_RID[i*ID_W +: ID_W];
        assign rdata_a[i] = sl_RDATA[i*DATA_W +: DATA_W];
        assign rresp_a[i] = sl_RRESP[i*2 +: 2];
        assign elig_c[i]  = sl_RVALID[i] && (sl_mas_sel[i*SEL_W +: SEL_W] == MAS_ID);
    end

    rr_picker #(
        .N     (NUM_SL),
        .IDX_W (IDX_W)
    ) u_picker (
        .req           (elig_c),
        .last_grant    (last_grant),
        .grant_c       (pick_c),
        .grant_valid_c (pick_valid_c)
    );

    // The output register can take a beat when it is empty or draining this cycle.
    assign out_free_c = !m_RVALID || m_RREADY;
    assign accept_c   = (state == ST_BURST) && sl_RVALID[grant] && out_free_c;

    // Ready goes only to the locked slave; it must follow m_RREADY in the same cycle.
    always_comb begin
        sl_RREADY = '0;
        if (state == ST_BURST && out_free_c) begin
            sl_RREADY[grant] = 1'b1;
        end
    end

    // Grant FSM, output register and beat counter.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_SL - 1);
            m_RVALID   <= 1'b0;
            m_RLAST    <= 1'b0;
            m_RID      <= '0;
            m_RDATA    <= '0;
            m_RRESP    <= RESP_OKAY;
            busy       <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            if (accept_c) begin
                m_RVALID <= 1'b1;
                m_RLAST  <= sl_RLAST[grant];
                m_RID    <= rid_a[grant];
                m_RDATA  <= rdata_a[grant];
                m_RRESP  <= rresp_a[grant];
            end else if (m_RREADY) begin
                m_RVALID <= 1'b0;
                m_RLAST  <= 1'b0;
                m_RID    <= '0;
                m_RDATA  <= '0;
                m_RRESP  <= RESP_OKAY;
            end

            case (state)
                ST_IDLE: begin
                    if (pick_valid_c) begin
                        grant    <= pick_c;
                        state    <= ST_BURST;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (accept_c) begin
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                        end
                        if (sl_RLAST[grant]) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_resp_arbiter.sv
// Testbench for rd_resp_arbiter (4 slaves): per-cycle vector table plus queue-driven scenarios
// checked against a burst-level round-robin reference model.
module tb_rd_resp_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;
    localparam logic [1:0]  MY_ID = 2'b01;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [NS-1:0]     sl_RVALID, sl_RLAST, sl_RREADY;
    logic [NS*IW-1:0]  sl_RID;
    logic [NS*DW-1:0]  sl_RDATA;
    logic [NS*2-1:0]   sl_RRESP;
    logic [NS*SW-1:0]  sl_mas_sel;
    logic              m_RVALID, m_RLAST, m_RREADY, busy;
    logic [IW-1:0]     m_RID;
    logic [DW-1:0]     m_RDATA;
    logic [1:0]        m_RRESP;
    logic [7:0]        beat_cnt;

    always #5 ACLK = ~ACLK;

    rd_resp_arbiter #(
        .NUM_SL (NS), .ID_W (IW), .DATA_W (DW), .SEL_W (SW), .MAS_ID (MY_ID)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .sl_RVALID (sl_RVALID), .sl_RLAST (sl_RLAST), .sl_RID (sl_RID),
        .sl_RDATA (sl_RDATA), .sl_RRESP (sl_RRESP), .sl_mas_sel (sl_mas_sel),
        .sl_RREADY (sl_RREADY),
        .m_RVALID (m_RVALID), .m_RLAST (m_RLAST), .m_RID (m_RID),
        .m_RDATA (m_RDATA), .m_RRESP (m_RRESP), .m_RREADY (m_RREADY),
        .busy (busy), .beat_cnt (beat_cnt)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        v0;
        logic        l0;
        logic [31:0] d0;
        logic        rdy;
        logic [3:0]  e_srdy;
        logic        e_mv;
        logic        e_ml;
        logic [31:0] e_md;
        logic [7:0]  e_rid;
        logic        e_busy;
        logic [7:0]  e_cnt;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    beat_t       mem [NS][32];
    int unsigned head [NS];
    int unsigned tail [NS];
    logic [1:0]  sel [NS];
    logic [NS-1:0] elig;
    beat_t       exp_q [$];
    logic        prev_load, prev_stall;
    beat_t       prev_beat, prev_out;

    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic beat_t cur_out();
        return beat_t'{id: m_RID, data: m_RDATA, resp: m_RRESP, last: m_RLAST};
    endfunction

    function automatic void clear_slaves();
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            tail[i] = 0;
            sel[i]  = MY_ID;
        end
        elig = '1;
    endfunction

    function automatic void update_elig();
        for (int i = 0; i < NS; i++) elig[i] = (sel[i] == MY_ID);
    endfunction

    function automatic void add_burst(input int s, input int n, input logic [7:0] id, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            mem[s][tail[s]] = beat_t'{id: id, data: base + 32'(k),
                                      resp: 2'($urandom_range(0, 3)), last: (k == n - 1)};
            tail[s]++;
        end
    endfunction

    // Reference: after reset slave 0 is first; each burst goes whole to the next eligible slave
    // after the previous winner that still has bursts queued.
    function automatic void build_expected();
        int unsigned ptr [NS];
        int unsigned last, pick, cand;
        bit found, done;
        exp_q.delete();
        for (int i = 0; i < NS; i++) ptr[i] = head[i];
        last = NS - 1;
        pick = 0;
        do begin
            found = 0;
            for (int unsigned k = 1; k <= NS; k++) begin
                cand = (last + k) % NS;
                if (!found && elig[cand] && ptr[cand] < tail[cand]) begin
                    found = 1;
                    pick  = cand;
                end
            end
            if (found) begin
                done = 0;
                while (!done) begin
                    exp_q.push_back(mem[pick][ptr[pick]]);
                    done = mem[pick][ptr[pick]].last;
                    ptr[pick]++;
                end
                last = pick;
            end
        end while (found);
    endfunction

    task automatic drive(input logic rdy);
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            if (head[i] < tail[i]) begin
                b = mem[i][head[i]];
                sl_RVALID[i] = 1'b1;
            end else begin
                b = '0;
                sl_RVALID[i] = 1'b0;
            end
            sl_RLAST[i]              = b.last;
            sl_RID[i*IW +: IW]       = b.id;
            sl_RDATA[i*DW +: DW]     = b.data;
            sl_RRESP[i*2 +: 2]       = b.resp;
            sl_mas_sel[i*SW +: SW]   = sel[i];
        end
        m_RREADY = rdy;
    endtask

    task automatic do_reset();
        ARESET     = 1'b1;
        sl_RVALID  = '0;
        sl_RLAST   = '0;
        sl_RID     = '0;
        sl_RDATA   = '0;
        sl_RRESP   = '0;
        sl_mas_sel = '0;
        m_RREADY   = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET     = 1'b0;
        prev_load  = 1'b0;
        prev_stall = 1'b0;
    endtask

    // One clock: drive at negedge, check outputs, then record handshakes at the edge.
    task automatic cycle(input logic rdy);
        logic [NS-1:0] acc;
        beat_t got, e;
        logic ok;
        @(negedge ACLK);
        drive(rdy);
        #1;
        got = cur_out();
        if (prev_load)
            check("load", m_RVALID && got == prev_beat, {20'd0, m_RVALID, got}, {20'd0, 1'b1, prev_beat});
        else if (prev_stall)
            check("hold", m_RVALID && got == prev_out, {20'd0, m_RVALID, got}, {20'd0, 1'b1, prev_out});
        else
            check("empty", !m_RVALID, 64'(m_RVALID), 64'd0);
        ok = ((sl_RREADY & ~elig) == '0) && $onehot0(sl_RREADY) &&
             !(m_RVALID && !m_RREADY && (sl_RREADY != '0));
        check("rready", ok, 64'(sl_RREADY), 64'(elig));
        if (m_RVALID && m_RREADY) begin
            if (exp_q.size() == 0) begin
                check("order extra", 1'b0, 64'(got), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("order", got == e, 64'(got), 64'(e));
            end
        end
        acc        = sl_RVALID & sl_RREADY;
        prev_stall = m_RVALID && !m_RREADY;
        prev_out   = got;
        prev_load  = 1'b0;
        @(posedge ACLK);
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                prev_load = 1'b1;
                prev_beat = mem[i][head[i]];
                head[i]++;
            end
        end
        #1;
    endtask

    // mode 0: always ready; 1: random ready; 2: ready low for cycles 3..5.
    task automatic drain(input int mode, input bit flip0, input string tag);
        int cyc;
        logic rdy;
        cyc = 0;
        while ((exp_q.size() != 0 || m_RVALID) && cyc < 400) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 9) < 7);
            else                rdy = !(cyc >= 3 && cyc <= 5);
            if (flip0 && head[0] >= 1) sel[0] = 2'b10;
            cycle(rdy);
            cyc++;
        end
        check({tag, " done"}, exp_q.size() == 0 && !m_RVALID, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [7];
        logic [54:0] act, expv;
        int n;

        // Single 4-beat burst from slave 0, one row per clock.
        tbl[0] = '{1'b1, 1'b0, 32'd1, 1'b1, 4'h0, 1'b0, 1'b0, 32'd0, 8'h00, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 32'd1, 1'b1, 4'h1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 32'd2, 1'b1, 4'h1, 1'b1, 1'b0, 32'd1, 8'h11, 1'b1, 8'd1};
        tbl[3] = '{1'b1, 1'b0, 32'd3, 1'b1, 4'h1, 1'b1, 1'b0, 32'd2, 8'h11, 1'b1, 8'd2};
        tbl[4] = '{1'b1, 1'b1, 32'd4, 1'b1, 4'h1, 1'b1, 1'b0, 32'd3, 8'h11, 1'b1, 8'd3};
        tbl[5] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'h0, 1'b1, 1'b1, 32'd4, 8'h11, 1'b0, 8'd4};
        tbl[6] = '{1'b0, 1'b0, 32'd0, 1'b1, 4'h0, 1'b0, 1'b0, 32'd0, 8'h00, 1'b0, 8'd4};

        clear_slaves();
        do_reset();
        check("reset", {m_RVALID, m_RLAST, m_RID, m_RDATA, m_RRESP, sl_RREADY, busy, beat_cnt} == '0,
              64'({m_RVALID, m_RLAST, m_RID, m_RDATA, m_RRESP, sl_RREADY, busy, beat_cnt}), 64'd0);

        for (int r = 0; r < 7; r++) begin
            @(negedge ACLK);
            sl_RVALID       = {3'b000, tbl[r].v0};
            sl_RLAST        = {3'b000, tbl[r].l0};
            sl_RDATA        = '0;
            sl_RDATA[31:0]  = tbl[r].d0;
            sl_RID          = '0;
            sl_RID[7:0]     = 8'h11;
            sl_RRESP        = '0;
            sl_mas_sel      = {NS{MY_ID}};
            m_RREADY        = tbl[r].rdy;
            #1;
            act  = {sl_RREADY, m_RVALID, m_RLAST, m_RDATA, m_RID, busy, beat_cnt};
            expv = {tbl[r].e_srdy, tbl[r].e_mv, tbl[r].e_ml, tbl[r].e_md, tbl[r].e_rid,
                    tbl[r].e_busy, tbl[r].e_cnt};
            check($sformatf("single row%0d", r), act == expv, 64'(act), 64'(expv));
        end

        // Contention: two 2-beat bursts, slave 0 first, no interleave.
        clear_slaves();
        add_burst(0, 2, 8'hA0, 32'h100);
        add_burst(1, 2, 8'hA1, 32'h200);
        do_reset();
        build_expected();
        drain(0, 1'b0, "contention");

        // Backpressure in the middle of a 4-beat burst.
        clear_slaves();
        add_burst(0, 4, 8'hB0, 32'h300);
        do_reset();
        build_expected();
        drain(2, 1'b0, "backpressure");

        // Foreign slave: never accepted, master stays idle.
        clear_slaves();
        sel[1] = 2'b10;
        update_elig();
        add_burst(1, 2, 8'hC1, 32'h400);
        do_reset();
        build_expected();
        repeat (6) cycle(1'b1);
        check("foreign untouched", head[1] == 0, 64'(head[1]), 64'd0);

        // Select change on the locked slave and other RVALIDs mid-burst do not move the grant.
        clear_slaves();
        add_burst(0, 3, 8'hD0, 32'h500);
        add_burst(1, 1, 8'hD1, 32'h600);
        do_reset();
        build_expected();
        drain(0, 1'b1, "lock");

        // Reset after beat 2 of 4: outputs drop at once; slave 0 goes first afterwards.
        clear_slaves();
        add_burst(0, 4, 8'hE0, 32'h700);
        add_burst(1, 2, 8'hE1, 32'h800);
        do_reset();
        build_expected();
        n = 0;
        while (head[0] < 2 && n < 20) begin
            cycle(1'b1);
            n++;
        end
        check("rst wait", head[0] == 2, 64'(head[0]), 64'd2);
        #2;
        ARESET = 1'b1;
        #1;
        check("async rst", {m_RVALID, m_RLAST, m_RID, m_RDATA, m_RRESP, sl_RREADY, busy, beat_cnt} == '0,
              64'({m_RVALID, m_RLAST, m_RID, m_RDATA, m_RRESP, sl_RREADY, busy, beat_cnt}), 64'd0);
        @(negedge ACLK);
        ARESET     = 1'b0;
        prev_load  = 1'b0;
        prev_stall = 1'b0;
        build_expected();
        drain(0, 1'b0, "post rst");

        // Rotation over four always-valid slaves with single-beat bursts.
        clear_slaves();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NS; i++)
                add_burst(i, 1, 8'(8'hF0 + i), 32'(i * 16 + k));
        do_reset();
        build_expected();
        drain(0, 1'b0, "rotation");

        // Random mixes of eligibility, burst lengths and master backpressure.
        for (int it = 0; it < 6; it++) begin
            clear_slaves();
            for (int i = 0; i < NS; i++) begin
                sel[i] = ($urandom_range(0, 3) != 0) ? MY_ID : 2'($urandom_range(2, 3));
                for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                    add_burst(i, int'($urandom_range(1, 4)), 8'($urandom), $urandom);
            end
            update_elig();
            do_reset();
            build_expected();
            drain(1, 1'b0, $sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rd_resp_arbiter.md
RD_RESP_ARBITER -- requirements
Module: rd_resp_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Parameter NUM_SL, default 2: number of slave read-data channels (2..8).
REQ-003 Parameter ID_W, default 8: RID width.
REQ-004 Parameter DATA_W, default 32: RDATA width.
REQ-005 Parameter SEL_W, default 2: width of each slave's master-select code.
REQ-006 Parameter MAS_ID, default 2'b01: select code that identifies this master.
REQ-007 Port ACLK, input, 1: clock; all state changes on its rising edge.
REQ-008 Port ARESET, input, 1: asynchronous active-high reset.
REQ-009 Port sl_RVALID, input, NUM_SL: per-slave RVALID, bit i = slave i.
REQ-010 Port sl_RLAST, input, NUM_SL: per-slave RLAST.
REQ-011 Port sl_RID, input, NUM_SL*ID_W: packed RIDs, slave i at [i*ID_W +: ID_W].
REQ-012 Port sl_RDATA, input, NUM_SL*DATA_W: packed RDATA, same packing.
REQ-013 Port sl_RRESP, input, NUM_SL*2: packed RRESP.
REQ-014 Port sl_mas_sel, input, NUM_SL*SEL_W: packed per-slave master-select codes.
REQ-015 Port sl_RREADY, output, NUM_SL: per-slave RREADY.
REQ-016 Port m_RVALID / m_RLAST, output, 1 each: master-side valid and last.
REQ-017 Port m_RID / m_RDATA / m_RRESP, output, ID_W / DATA_W / 2: master-side payload.
REQ-018 Port m_RREADY, input, 1: master-side ready.
REQ-019 Port busy, output, 1: high while a burst is locked (state BURST).
REQ-020 Port beat_cnt, output, 8: beats accepted in the current burst, saturating at 255.

Function
REQ-021 Slave i SHALL be eligible when sl_RVALID[i]=1 and its sl_mas_sel field equals MAS_ID.
REQ-022 The FSM SHALL have two states: IDLE and BURST.
REQ-023 In IDLE with at least one eligible slave, the block SHALL grant one slave round-robin, searching from last_grant+1 upward with wrap modulo NUM_SL, and move to BURST on the next edge.
REQ-024 In IDLE, all sl_RREADY bits SHALL be 0.
REQ-025 In BURST, sl_RREADY[grant] SHALL be high whenever the output register is empty or m_RREADY=1; all other sl_RREADY bits SHALL be 0.
REQ-026 A slave beat accepted (sl_RVALID & sl_RREADY) SHALL load the output register and appear on the m_R* ports on the following cycle: latency of exactly 1 cycle.
REQ-027 m_RVALID SHALL hold, with a stable payload, until m_RREADY=1; the register SHALL clear when it drains and no new beat is loaded.
REQ-028 Within a burst, throughput SHALL be one beat per cycle while m_RREADY stays high.
REQ-029 The grant SHALL stay locked to the granted slave until that slave's RLAST beat is accepted; the FSM SHALL then return to IDLE and set last_grant to the granted slave.
REQ-030 Changes to sl_mas_sel or to other slaves' RVALID during BURST SHALL NOT affect the grant.
REQ-031 beat_cnt SHALL clear on entry to BURST and increment on each accepted slave beat.
REQ-032 When the RLAST beat drains on the same cycle that a new grant is made, there SHALL be no bubble beyond the one-cycle IDLE arbitration cycle.
REQ-033 Non-eligible RVALIDs SHALL never be accepted.

Reset
REQ-034 On ARESET the block SHALL immediately enter IDLE and clear m_RVALID, m_RLAST, m_RID, m_RDATA, m_RRESP, sl_RREADY, busy and beat_cnt to 0.
REQ-035 On ARESET, last_grant SHALL be set to NUM_SL-1 so that slave 0 has first priority.
REQ-036 A reset mid-burst SHALL discard the in-flight beat; there SHALL be no partial output after reset.

Structure
REQ-037 The FSM state encoding and the RRESP codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) SHALL live in the shared AXI package.
REQ-038 The round-robin selector SHALL be a sub-module named rr_picker (inputs: request vector and last_grant; outputs: grant index and grant-valid).

Verification
REQ-039 Single burst: slave0 sends 4 beats, RID 8'h11, RDATA 1..4, with m_RREADY=1 -> m_RDATA 1,2,3,4 on consecutive cycles, m_RLAST on beat 4, beat_cnt=4, then busy=0.
REQ-040 Contention: slave0 and slave1 both valid from reset, 2-beat bursts each -> slave0's burst is forwarded fully first, then slave1's; no interleaving.
REQ-041 Backpressure: m_RREADY held 0 for 3 cycles mid-burst -> m_RDATA is held stable, sl_RREADY[grant]=0, and no beat is lost or duplicated.
REQ-042 Foreign beat: slave1 RVALID=1 with sl_mas_sel=2'b10 -> sl_RREADY[1] stays 0 and m_RVALID stays 0.
REQ-043 Reset mid-burst: ARESET asserted after beat 2 of 4 -> all outputs go to 0 asynchronously; after release, slave0 is granted first.
REQ-044 NUM_SL=4 rotation: all four slaves continuously valid with 1-beat bursts -> grants follow the order 0,1,2,3,0.
